// File: rtl/uart_framer_pkg.sv
// rtl/uart_framer_pkg.sv - shared types and constants for the UART TX packet framer
package uart_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_FETCH,
    ST_CSUM,
    ST_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    IS_EMIT,
    IS_GUARD,
    IS_DRAIN
  } issue_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte that brings the running payload sum to zero mod 256.
  function automatic logic [7:0] csum_byte(input logic [7:0] sum);
    return 8'h00 - sum;
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - word stream in, byte-sender handshake out, packet status
interface uart_tx_framer_if #(
  parameter int WORD_BYTES = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic [8*WORD_BYTES-1:0] s_data;
  logic                    s_last;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    tx_busy;
  logic                    pkt_done;
  logic                    active;

  modport master (
    input  s_valid, s_data, s_last, tx_busy,
    output s_ready, tx_start, tx_data, pkt_done, active
  );

  modport slave (
    output s_valid, s_data, s_last, tx_busy,
    input  s_ready, tx_start, tx_data, pkt_done, active
  );
endinterface

// File: rtl/uart_byte_issue.sv
// rtl/uart_byte_issue.sv - one-byte start/busy handshake with a blind guard cycle
module uart_byte_issue
  import uart_framer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_ack
);

  issue_state_e r_state;
  issue_state_e w_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IS_EMIT;
    else        r_state <= w_next;
  end

  // GUARD covers the cycle where the sender has not yet raised busy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IS_EMIT:  if (i_req && !i_tx_busy) w_next = IS_GUARD;
      IS_GUARD: w_next = IS_DRAIN;
      IS_DRAIN: if (!i_tx_busy) w_next = IS_EMIT;
      default:  w_next = IS_EMIT;
    endcase
  end

  always_comb begin
    o_tx_start = 1'b0;
    o_tx_data  = 8'h00;
    o_ack      = 1'b0;
    if (rst_n) begin
      case (r_state)
        IS_EMIT: begin
          if (i_req && !i_tx_busy) begin
            o_tx_start = 1'b1;
            o_tx_data  = i_byte;
          end
        end
        IS_DRAIN: o_ack = !i_tx_busy;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - frames words as SYNC, LSB-first payload, two's-complement checksum
module uart_tx_framer
  import uart_framer_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_framer_if.master  bus
);

  localparam int         W        = 8 * WORD_BYTES;
  localparam logic [3:0] LAST_IDX = 4'(WORD_BYTES - 1);

  frame_state_e r_state;
  frame_state_e w_next;
  logic [W-1:0] r_shreg;
  logic         r_last;
  logic [3:0]   r_byte_cnt;
  logic [7:0]   r_csum;
  logic         r_req;
  logic [7:0]   r_byte;
  logic [7:0]   w_byte_sel;
  logic         w_xfer;
  logic         w_ack;
  logic         w_issue;

  assign w_xfer  = bus.s_valid && bus.s_ready;
  assign w_issue = (r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_CSUM);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_next = ST_HDR;
      ST_HDR:   if (w_ack) w_next = ST_PAY;
      ST_PAY: begin
        if (w_ack && (r_byte_cnt == LAST_IDX)) w_next = r_last ? ST_CSUM : ST_FETCH;
      end
      ST_FETCH: if (w_xfer) w_next = ST_PAY;
      ST_CSUM:  if (w_ack) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready  = rst_n && ((r_state == ST_IDLE) || (r_state == ST_FETCH));
    bus.pkt_done = rst_n && (r_state == ST_DONE);
    bus.active   = rst_n && (r_state != ST_IDLE);
  end

  always_comb begin
    w_byte_sel = 8'h00;
    case (r_state)
      ST_HDR:  w_byte_sel = SYNC_BYTE;
      ST_PAY:  w_byte_sel = r_shreg[7:0];
      ST_CSUM: w_byte_sel = csum_byte(r_csum);
      default: w_byte_sel = 8'h00;
    endcase
  end

  // The request is raised one cycle after entering an issue state so the
  // outgoing byte is captured from settled shift/checksum registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_last     <= 1'b0;
      r_byte_cnt <= 4'd0;
      r_csum     <= 8'h00;
      r_req      <= 1'b0;
      r_byte     <= 8'h00;
    end else begin
      if (w_xfer) begin
        r_shreg    <= bus.s_data;
        r_last     <= bus.s_last;
        r_byte_cnt <= 4'd0;
      end
      if (w_ack) begin
        r_req <= 1'b0;
      end else if (w_issue && !r_req) begin
        r_req  <= 1'b1;
        r_byte <= w_byte_sel;
      end
      if (w_ack && (r_state == ST_PAY)) begin
        r_csum     <= r_csum + r_shreg[7:0];
        r_shreg    <= r_shreg >> 8;
        r_byte_cnt <= r_byte_cnt + 4'd1;
      end
      if (r_state == ST_DONE) r_csum <= 8'h00;
    end
  end

  uart_byte_issue u_issue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (r_req),
    .i_byte     (r_byte),
    .i_tx_busy  (bus.tx_busy),
    .o_tx_start (bus.tx_start),
    .o_tx_data  (bus.tx_data),
    .o_ack      (w_ack)
  );

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed and randomized packets against a byte-level packet model
module tb_uart_tx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_framer_if #(.WORD_BYTES(4)) bus ();

  uart_tx_framer #(.WORD_BYTES(4), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int busy_len = 11;
  int busy_cnt = 0;
  bit pend = 0;
  bit hold_busy = 0;
  bit prev_start = 0;
  bit gap_mon = 0;
  int gap_starts = 0;
  int gap_ready_low = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int start_q[$];
  int xfer_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Byte sender: busy for busy_len cycles starting the cycle after a start.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend) begin
      busy_cnt = busy_len;
      pend = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = hold_busy || (busy_cnt > 0);
  end

  always @(negedge clk) begin
    if (bus.tx_start) begin
      got.push_back(bus.tx_data);
      start_q.push_back(cyc);
      n_start++;
      checks++;
      assert (!prev_start && !bus.tx_busy) else begin
        errors++;
        $error("FAIL start_rule: prev_start=%0b tx_busy=%0b expected 0 and 0", prev_start, bus.tx_busy);
      end
      pend = 1;
    end
    prev_start = bus.tx_start;
    if (bus.pkt_done) n_done++;
    if (bus.s_valid && bus.s_ready) xfer_q.push_back(cyc);
    if (gap_mon) begin
      if (bus.tx_start) gap_starts++;
      if (!bus.s_ready) gap_ready_low++;
    end
  end

  task automatic model_pkt(input logic [31:0] words[$]);
    int sum;
    logic [7:0] b;
    sum = 0;
    exp_q.push_back(8'hA5);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((words[i] >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
        sum += int'(b);
      end
    end
    exp_q.push_back(8'((256 - (sum % 256)) % 256));
  endtask

  task automatic clear_obs();
    got.delete();
    exp_q.delete();
    start_q.delete();
    xfer_q.delete();
    n_start = 0;
    n_done = 0;
  endtask

  task automatic check_bytes(input string tag);
    int n;
    chk({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
  endtask

  // Entered and left just after a rising edge.
  task automatic push_word(input logic [31:0] d, input bit last, input bit drop);
    int b;
    bit ok;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    b = 0;
    ok = 0;
    while (!ok && b < 3000) begin
      @(negedge clk);
      if (bus.s_ready) ok = 1;
      b++;
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk);
    #2;
    if (drop) bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (n_done < target && b < 5000) begin
      @(negedge clk);
      b++;
    end
    chk("pkt_done_count", n_done, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_pkt_done"}, bus.pkt_done, 0);
    chk({tag, "_active"}, bus.active, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
  endtask

  initial begin
    logic [31:0] words[$];
    int b;
    int nw;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.tx_busy = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", bus.s_ready, 1);
    chk("idle_active", bus.active, 0);

    // Single word packet
    clear_obs();
    busy_len = 11;
    @(posedge clk);
    #2;
    push_word(32'h04030201, 1, 1);
    @(negedge clk);
    chk("t1_active", bus.active, 1);
    wait_done(1);
    words = '{32'h04030201};
    model_pkt(words);
    check_bytes("t1");
    chk("t1_starts", n_start, 6);
    if (got.size() == 6) chk("t1_csum", got[5], 8'hF6);
    if (start_q.size() > 0 && xfer_q.size() > 0) chk("t1_latency", start_q[0] - xfer_q[0], 2);
    else chk("t1_latency_seen", 0, 1);
    @(negedge clk);
    chk("t1_active_after", bus.active, 0);

    // Checksum wrap across two words
    clear_obs();
    busy_len = 3;
    @(posedge clk);
    #2;
    push_word(32'h00000001, 0, 1);
    push_word(32'h000000FF, 1, 1);
    wait_done(1);
    words = '{32'h00000001, 32'h000000FF};
    model_pkt(words);
    check_bytes("t2");
    if (got.size() == 10) chk("t2_csum", got[9], 8'h00);

    // Input stalled between words
    clear_obs();
    busy_len = 2;
    @(posedge clk);
    #2;
    push_word(32'h11223344, 0, 1);
    b = 0;
    while (!bus.s_ready && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("t3_fetch_reached", bus.s_ready, 1);
    gap_starts = 0;
    gap_ready_low = 0;
    gap_mon = 1;
    repeat (50) @(negedge clk);
    gap_mon = 0;
    chk("t3_gap_starts", gap_starts, 0);
    chk("t3_gap_ready_low", gap_ready_low, 0);
    @(posedge clk);
    #2;
    push_word(32'h55667788, 1, 1);
    wait_done(1);
    words = '{32'h11223344, 32'h55667788};
    model_pkt(words);
    check_bytes("t3");

    // Sender busy while the first byte waits
    clear_obs();
    busy_len = 5;
    @(posedge clk);
    #2 hold_busy = 1;
    push_word(32'hCAFEF00D, 1, 1);
    repeat (200) @(negedge clk);
    chk("t4_hold_no_start", n_start, 0);
    @(posedge clk);
    #2 hold_busy = 0;
    b = 0;
    while (n_start < 1 && b < 10) begin
      @(negedge clk);
      b++;
    end
    chk("t4_one_pulse", n_start, 1);
    @(negedge clk);
    chk("t4_no_second_pulse", n_start, 1);
    if (got.size() > 0) chk("t4_first_byte", got[0], 8'hA5);
    wait_done(1);
    words = '{32'hCAFEF00D};
    model_pkt(words);
    check_bytes("t4");

    // Reset during the third payload byte, then a fresh packet
    clear_obs();
    busy_len = 6;
    @(posedge clk);
    #2;
    push_word(32'h0A0B0C0D, 1, 1);
    b = 0;
    while (got.size() < 4 && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("t5_third_payload_seen", got.size(), 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_obs();
    push_word(32'hAABBCCDD, 1, 1);
    wait_done(1);
    words = '{32'hAABBCCDD};
    model_pkt(words);
    check_bytes("t5");

    // Back-to-back packets with s_valid held
    clear_obs();
    busy_len = 4;
    @(posedge clk);
    #2;
    push_word(32'h01020304, 1, 0);
    push_word(32'h80706050, 1, 1);
    wait_done(2);
    words = '{32'h01020304};
    model_pkt(words);
    words = '{32'h80706050};
    model_pkt(words);
    check_bytes("t6");
    chk("t6_xfers", xfer_q.size(), 2);

    // Randomized packets and sender timing
    for (int p = 0; p < 4; p++) begin
      clear_obs();
      busy_len = int'($urandom_range(1, 12));
      nw = int'($urandom_range(1, 3));
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      @(posedge clk);
      #2;
      for (int i = 0; i < nw; i++) push_word(words[i], (i == nw - 1), 1);
      wait_done(1);
      model_pkt(words);
      check_bytes($sformatf("rand%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
